requant: RTL and testbench
==========================

REQUANT -- requirements
Module: requant

Interface
REQ-001 SHALL have parameter LANES, default 4: number of independent data lanes.
REQ-002 SHALL have parameter IN_W, default 24: input lane width in bits.
REQ-003 SHALL have parameter OUT_W, default 8: output lane width in bits (OUT_W < IN_W).
REQ-004 SHALL have parameter SHIFT_W, default 5: width of the shift control.
REQ-005 SHALL have port clk  input  1: single clock, rising edge.
REQ-006 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-007 SHALL have port in_valid  input  1: input beat valid.
REQ-008 SHALL have port in_ready  output  1: block can accept a beat.
REQ-009 SHALL have port in_data  input  LANES*IN_W: lane i at bits [i*IN_W +: IN_W].
REQ-010 SHALL have port in_lane_en  input  LANES: per-lane data valid.
REQ-011 SHALL have port shift  input  SHIFT_W: right-shift amount.
REQ-012 SHALL have port round_en  input  1: round-half-up when 1, truncate when 0.
REQ-013 SHALL have port signed_mode  input  1: two's-complement lanes when 1, unsigned when 0.
REQ-014 SHALL have port out_valid  output  1: output beat valid.
REQ-015 SHALL have port out_ready  input  1: downstream accepts the beat.
REQ-016 SHALL have port out_data  output  LANES*OUT_W: lane i at bits [i*OUT_W +: OUT_W].
REQ-017 SHALL have port out_lane_en  output  LANES: in_lane_en carried with the beat.
REQ-018 SHALL have port sat_flags  output  LANES: lane i clamped in this beat.
REQ-019 SHALL have port clr_sat  input  1: synchronous clear of sat_count.
REQ-020 SHALL have port sat_count  output  16: cumulative saturation-event count.

Function
REQ-021 SHALL accept a beat when in_valid && in_ready; shift, round_en, signed_mode and in_lane_en are sampled with that beat.
REQ-022 SHALL be a 2-stage pipeline (S1: shift/round; S2: clamp/register); out_valid rises exactly 2 cycles after acceptance if not stalled.
REQ-023 SHALL advance S2 when !s2_valid || out_ready; S1 when !s1_valid || S2 advances; in_ready = !s1_valid || S2 advances.
REQ-024 SHALL hold out_data, out_lane_en and sat_flags stable while out_valid && !out_ready; no beat is lost, duplicated or reordered.
REQ-025 SHALL compute in IN_W+1 bits; rounding adds 2^(shift-1) before the shift (none when shift=0); signed mode uses an arithmetic shift.
REQ-026 SHALL treat shift values greater than IN_W-1 as IN_W-1.
REQ-027 SHALL clamp unsigned results to [0, 2^OUT_W-1] and signed results to [-2^(OUT_W-1), 2^(OUT_W-1)-1], setting the lane's sat_flags bit when clamped.
REQ-028 SHALL drive out_data lane to 0 and sat_flags bit to 0 for any lane whose in_lane_en bit was 0.
REQ-029 SHALL, on each output handshake, add popcount(sat_flags) to sat_count, saturating at 16'hFFFF (no wrap).
REQ-030 SHALL give clr_sat priority over a same-cycle increment (result 0).

Reset
REQ-031 SHALL, while rst_n=0, force out_valid=0, in_ready=0, out_data=0, out_lane_en=0, sat_flags=0, sat_count=0, and drop all in-flight beats.
REQ-032 SHALL assert in_ready in the first cycle after rst_n deasserts.

Configuration
REQ-033 SHALL include the sat_count accumulator only when macro REQUANT_SAT_CNT_EN is defined; otherwise sat_count SHALL be tied to 0 and clr_sat ignored, with all other behaviour unchanged.

Verification (LANES=4, IN_W=24, OUT_W=8)
REQ-034 SHALL verify unsigned, shift=0, lanes {100,255,256,24'hFFFFFF} -> out {100,255,255,255}, sat_flags=4'b1100, out_valid 2 cycles later, sat_count=2.
REQ-035 SHALL verify shift=4: input 24 with round_en=1 -> 2; input 23 with round_en=1 -> 1; input 24 with round_en=0 -> 1.
REQ-036 SHALL verify signed, shift=0, lanes {-200,127,128,-128} -> out {8'h80,8'h7F,8'h7F,8'h80}, sat_flags=4'b0101.
REQ-037 SHALL verify out_ready=0 for 6 cycles while 4 beats are offered -> in_ready drops after 2 beats are accepted; all 4 beats emerge in order with no loss or duplication.
REQ-038 SHALL verify rst_n pulsed low with 2 beats in flight -> out_valid=0 and sat_count=0 immediately, and no stale beat appears after release.
REQ-039 SHALL verify, with REQUANT_SAT_CNT_EN, 16384 fully saturated beats -> sat_count=16'hFFFF that holds on further beats; clr_sat -> 0; without the macro, sat_count stays 0.

Source files
------------

// File: rtl/requant.sv
// requant: per-lane shift/round/clamp requantizer, 2-stage valid/ready pipe.
// Ports: in_* beat (data, lane_en, shift, round_en, signed_mode), out_* beat
// (data, lane_en, sat_flags), clr_sat/sat_count saturation counter.
// Optional: define REQUANT_SAT_CNT_EN to build the sat_count accumulator;
// otherwise sat_count is tied to 0 and clr_sat is ignored.
module requant #(
  parameter int LANES   = 4,
  parameter int IN_W    = 24,
  parameter int OUT_W   = 8,
  parameter int SHIFT_W = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*IN_W-1:0]  in_data,
  input  logic [LANES-1:0]       in_lane_en,
  input  logic [SHIFT_W-1:0]     shift,
  input  logic                   round_en,
  input  logic                   signed_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_W-1:0] out_data,
  output logic [LANES-1:0]       out_lane_en,
  output logic [LANES-1:0]       sat_flags,
  input  logic                   clr_sat,
  output logic [15:0]            sat_count
);

  localparam int XW = IN_W + 1;
  localparam logic [31:0] SH_MAX = 32'(IN_W - 1);

  logic                  s1_valid;
  logic                  s2_valid;
  logic                  s1_adv;
  logic                  s2_adv;
  logic                  accept;
  logic [LANES*XW-1:0]   s1_val;
  logic [LANES-1:0]      s1_en;
  logic                  s1_sgn;
  logic [SHIFT_W-1:0]    sh;
  logic [LANES*XW-1:0]   s1_d;
  logic [LANES*OUT_W-1:0] c_data;
  logic [LANES-1:0]      c_flag;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  // rst_n gates in_ready so it is low during reset, high right after.
  assign in_ready  = rst_n && s1_adv;
  assign accept    = in_valid && in_ready;
  assign out_valid = s2_valid;

  always_comb begin
    sh = shift;
    if ({{(32-SHIFT_W){1'b0}}, shift} > SH_MAX) begin
      sh = SHIFT_W'(SH_MAX);
    end
  end

  // S1: widen by one bit so rounding cannot overflow, then shift.
  always_comb begin
    s1_d = '0;
    for (int i = 0; i < LANES; i++) begin
      logic [XW-1:0] x;
      if (signed_mode) begin
        x = {in_data[i*IN_W+IN_W-1], in_data[i*IN_W +: IN_W]};
      end else begin
        x = {1'b0, in_data[i*IN_W +: IN_W]};
      end
      if (round_en && sh != '0) begin
        x = x + (XW'(1) << (sh - 1'b1));
      end
      if (signed_mode) begin
        x = XW'($signed(x) >>> sh);
      end else begin
        x = x >> sh;
      end
      s1_d[i*XW +: XW] = x;
    end
  end

  // S2 input: clamp to the output range, zero disabled lanes.
  always_comb begin
    c_data = '0;
    c_flag = '0;
    for (int i = 0; i < LANES; i++) begin
      logic [XW-1:0] r;
      r = s1_val[i*XW +: XW];
      if (s1_en[i]) begin
        if (s1_sgn) begin
          if (&r[XW-1:OUT_W-1] || ~|r[XW-1:OUT_W-1]) begin
            c_data[i*OUT_W +: OUT_W] = r[OUT_W-1:0];
          end else begin
            c_flag[i] = 1'b1;
            c_data[i*OUT_W +: OUT_W] = r[XW-1] ?
              {1'b1, {(OUT_W-1){1'b0}}} :
              {1'b0, {(OUT_W-1){1'b1}}};
          end
        end else begin
          if (~|r[XW-1:OUT_W]) begin
            c_data[i*OUT_W +: OUT_W] = r[OUT_W-1:0];
          end else begin
            c_flag[i] = 1'b1;
            c_data[i*OUT_W +: OUT_W] = '1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_val   <= '0;
      s1_en    <= '0;
      s1_sgn   <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= accept;
      if (accept) begin
        s1_val <= s1_d;
        s1_en  <= in_lane_en;
        s1_sgn <= signed_mode;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid    <= 1'b0;
      out_data    <= '0;
      out_lane_en <= '0;
      sat_flags   <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_data    <= c_data;
        out_lane_en <= s1_en;
        sat_flags   <= c_flag;
      end
    end
  end

`ifdef REQUANT_SAT_CNT_EN
  logic [15:0] cnt;
  logic [16:0] pop;
  logic [16:0] sum;

  always_comb begin
    pop = '0;
    for (int i = 0; i < LANES; i++) begin
      pop = pop + 17'(sat_flags[i]);
    end
    sum = {1'b0, cnt} + pop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr_sat) begin
      cnt <= '0;
    end else if (s2_valid && out_ready) begin
      cnt <= sum[16] ? 16'hFFFF : sum[15:0];
    end
  end

  assign sat_count = cnt;
`else
  logic unused_clr;
  assign unused_clr = clr_sat;
  assign sat_count  = '0;
`endif

endmodule

// File: tb/tb_requant.sv
// tb_requant: randomized + directed bench for requant with a queue model.
// Reference computes each lane with integer arithmetic and range clamps.
module tb_requant;

`ifdef REQUANT_SAT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [95:0] in_data;
  logic [3:0]  in_lane_en;
  logic [4:0]  shift;
  logic        round_en;
  logic        signed_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_lane_en;
  logic [3:0]  sat_flags;
  logic        clr_sat;
  logic [15:0] sat_count;

  requant dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_lane_en(in_lane_en),
    .shift(shift), .round_en(round_en),
    .signed_mode(signed_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_lane_en(out_lane_en),
    .sat_flags(sat_flags), .clr_sat(clr_sat),
    .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  f;
    logic [3:0]  en;
  } beat_t;

  beat_t q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    nout    = 0;
  int    nacc    = 0;
  longint cnt_m  = 0;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t ref_beat(input logic [95:0] d,
                                     input logic [3:0] en,
                                     input logic [4:0] sh,
                                     input logic rnd,
                                     input logic sgn);
    beat_t b;
    b.d  = '0;
    b.f  = '0;
    b.en = en;
    for (int i = 0; i < 4; i++) begin
      logic [23:0] x;
      longint v;
      longint lo;
      longint hi;
      int s;
      x = d[i*24 +: 24];
      v = sgn ? longint'($signed(x)) : longint'(x);
      s = (sh > 5'd23) ? 23 : int'(sh);
      if (rnd && s > 0) v = v + (longint'(1) << (s - 1));
      v  = v >>> s;
      lo = sgn ? -128 : 0;
      hi = sgn ? 127 : 255;
      if (en[i]) begin
        if (v > hi) begin
          b.d[i*8 +: 8] = 8'(hi);
          b.f[i] = 1'b1;
        end else if (v < lo) begin
          b.d[i*8 +: 8] = 8'(lo);
          b.f[i] = 1'b1;
        end else begin
          b.d[i*8 +: 8] = 8'(v);
        end
      end
    end
    return b;
  endfunction

  // Monitor: inputs only change at posedge+1, so values seen at negedge
  // are those the next rising edge will act on.
  logic        stl = 1'b0;
  logic [31:0] hd;
  logic [3:0]  hf;
  logic [3:0]  he;

  always @(negedge clk) begin
    beat_t e;
    longint pop;
    if (!rst_n) begin
      q.delete();
      cnt_m = 0;
      stl   = 1'b0;
    end else begin
      check("sat_count", 64'(sat_count), 64'(cnt_m));
      if (stl) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_data", 64'(out_data), 64'(hd));
        check("hold_flags", 64'(sat_flags), 64'(hf));
        check("hold_en", 64'(out_lane_en), 64'(he));
      end
      stl = out_valid && !out_ready;
      hd  = out_data;
      hf  = sat_flags;
      he  = out_lane_en;
      pop = 0;
      if (out_valid && out_ready) begin
        nout++;
        check("q_nonempty", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check("out_data", 64'(out_data), 64'(e.d));
          check("out_flags", 64'(sat_flags), 64'(e.f));
          check("out_en", 64'(out_lane_en), 64'(e.en));
          pop = longint'($countones(e.f));
        end
      end
      if (CNT_EN) begin
        if (clr_sat) cnt_m = 0;
        else cnt_m = (cnt_m + pop > 65535) ? 65535 : cnt_m + pop;
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_beat(in_data, in_lane_en, shift,
                             round_en, signed_mode));
        nacc++;
      end
    end
  end

  task automatic idle();
    in_valid    = 1'b0;
    in_data     = '0;
    in_lane_en  = '0;
    shift       = '0;
    round_en    = 1'b0;
    signed_mode = 1'b0;
    clr_sat     = 1'b0;
  endtask

  task automatic rst_pulse();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 check("rdy_after_rst", 64'(in_ready), 64'd1);
  endtask

  task automatic send(input logic [95:0] d, input logic [3:0] en,
                      input logic [4:0] sh, input logic rnd,
                      input logic sgn);
    bit ok;
    in_data     = d;
    in_lane_en  = en;
    shift       = sh;
    round_en    = rnd;
    signed_mode = sgn;
    in_valid    = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("send_timeout", 64'(ok), 64'd1);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] rnd_lane();
    case ($urandom_range(0, 3))
      0: return 24'($urandom_range(0, 300));
      1: return 24'($urandom);
      2: return 24'hFFFFFF - 24'($urandom_range(0, 300));
      default: return 24'h800000 + 24'($urandom_range(0, 600)) - 24'd300;
    endcase
  endfunction

  initial begin
    logic [95:0] b[4];
    int acc;
    int snap;
    idle();
    out_ready = 1'b0;
    rst_n = 1'b0;
    #2;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_flags", 64'(sat_flags), 64'd0);
    check("rst_en", 64'(out_lane_en), 64'd0);
    check("rst_cnt", 64'(sat_count), 64'd0);
    @(posedge clk);
    rst_pulse();
    out_ready = 1'b1;

    // unsigned clamp, latency and counter
    send({24'hFFFFFF, 24'd256, 24'd255, 24'd100}, 4'hF, 5'd0, 1'b0, 1'b0);
    check("lat_s1", 64'(out_valid), 64'd0);
    step(1);
    check("lat_s2", 64'(out_valid), 64'd1);
    check("d034", 64'(out_data), 64'hFFFFFF64);
    check("f034", 64'(sat_flags), 64'hC);
    step(1);
    check("cnt034", 64'(sat_count), CNT_EN ? 64'd2 : 64'd0);

    // rounding vs truncation at shift=4
    send({24'd0, 24'd0, 24'd23, 24'd24}, 4'h3, 5'd4, 1'b1, 1'b0);
    step(1);
    check("d035r", 64'(out_data), 64'h00000102);
    send({24'd0, 24'd0, 24'd0, 24'd24}, 4'h1, 5'd4, 1'b0, 1'b0);
    step(1);
    check("d035t", 64'(out_data), 64'h00000001);

    // signed clamp
    send({24'hFFFF80, 24'd128, 24'd127, 24'hFFFF38}, 4'hF, 5'd0,
         1'b0, 1'b1);
    step(1);
    check("d036", 64'(out_data), 64'h807F7F80);
    check("f036", 64'(sat_flags), 64'h5);
    step(2);

    // backpressure: 4 beats offered with out_ready held low
    for (int i = 0; i < 4; i++)
      b[i] = {rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane()};
    out_ready   = 1'b0;
    in_lane_en  = 4'hF;
    shift       = 5'd3;
    round_en    = 1'b1;
    signed_mode = 1'b1;
    acc  = 0;
    snap = nout;
    for (int c = 0; c < 6; c++) begin
      in_data  = b[acc];
      in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) acc++;
      @(posedge clk);
      #1;
    end
    check("stall_acc", 64'(acc), 64'd2);
    check("stall_rdy", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    for (int c = 0; c < 50 && acc < 4; c++) begin
      in_data  = b[acc];
      in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) acc++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    step(4);
    check("stall_out", 64'(nout - snap), 64'd4);
    check("stall_q", 64'(q.size()), 64'd0);

    // reset with 2 beats in flight
    out_ready = 1'b0;
    send({24'd5, 24'd6, 24'd7, 24'd8}, 4'hF, 5'd0, 1'b0, 1'b0);
    send({24'hFFFFFF, 24'd6, 24'd7, 24'd8}, 4'hF, 5'd0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rst2_valid", 64'(out_valid), 64'd0);
    check("rst2_cnt", 64'(sat_count), 64'd0);
    check("rst2_ready", 64'(in_ready), 64'd0);
    check("rst2_data", 64'(out_data), 64'd0);
    check("rst2_flags", 64'(sat_flags), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    snap = nout;
    step(6);
    check("no_stale", 64'(nout - snap), 64'd0);

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 2) != 0);
      in_data     = {rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane()};
      in_lane_en  = 4'($urandom);
      shift       = 5'($urandom);
      round_en    = 1'($urandom);
      signed_mode = 1'($urandom);
      clr_sat     = ($urandom_range(0, 15) == 0);
      step(1);
    end
    idle();
    out_ready = 1'b1;
    step(5);
    check("rand_q", 64'(q.size()), 64'd0);

    // counter saturation, hold and clear
    rst_n = 1'b0;
    @(posedge clk);
    rst_pulse();
    out_ready  = 1'b1;
    in_data    = {4{24'hFFFFFF}};
    in_lane_en = 4'hF;
    snap       = nacc;
    in_valid   = 1'b1;
    for (int c = 0; c < 20000 && (nacc - snap) < 16384; c++) step(1);
    in_valid = 1'b0;
    step(4);
    check("cnt_max", 64'(sat_count), CNT_EN ? 64'hFFFF : 64'd0);
    in_valid = 1'b1;
    step(5);
    in_valid = 1'b0;
    step(4);
    check("cnt_hold", 64'(sat_count), CNT_EN ? 64'hFFFF : 64'd0);
    in_valid = 1'b1;
    step(3);
    clr_sat = 1'b1;
    check("clr_hs", 64'(out_valid), 64'd1);
    step(1);
    clr_sat  = 1'b0;
    in_valid = 1'b0;
    check("cnt_clr", 64'(sat_count), 64'd0);
    step(5);
    check("end_q", 64'(q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
